// File: rtl/alarm_time_editor.sv
// Alarm time editor: holds the committed HH:MM alarm (BCD) and edits a working copy digit by digit.
// Optional display blinking of the selected digit is enabled with `define EDIT_BLINK_EN.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | not editing; display shows the committed alarm time
// EDIT  | working copy shown and adjusted; active falling commits it
// ABORT | edit cancelled; wait for active to drop before returning
module alarm_time_editor #(
    parameter logic [15:0] RESET_BCD = 16'h0600,
    parameter int          BLINK_DIV = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        active,
    input  logic [7:0]  sel,
    input  logic        up,
    input  logic        down,
    input  logic        cancel,
    output logic [15:0] alarm_bcd,
    output logic [15:0] disp_bcd,
    output logic        editing,
    output logic        saved,
    output logic [3:0]  blank_mask
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EDIT  = 2'd1,
        ABORT = 2'd2
    } state_t;

    state_t      state;
    logic        active_q;
    logic [15:0] working;

    logic        sel_one;
    logic        edit_req;
    logic [3:0]  hr_tens, hr_ones, min_tens, min_ones;
    logic [3:0]  n_hr_tens, n_hr_ones, n_min_tens, n_min_ones;
    logic [15:0] edit_bcd;

    logic        unused_sel_hi;
    assign unused_sel_hi = ^sel[7:4];

    // One wrapping step of a single digit; codes above max_v wrap to 0 defensively.
    function automatic logic [3:0] digit_step(input logic [3:0] v,
                                              input logic [3:0] max_v,
                                              input logic       inc);
        if (inc)
            return (v >= max_v) ? 4'd0 : v + 4'd1;
        else
            return (v == 4'd0) ? max_v : v - 4'd1;
    endfunction

    always_comb begin
        sel_one  = $onehot(sel[3:0]);
        edit_req = sel_one && (up ^ down);
        {hr_tens, hr_ones, min_tens, min_ones} = working;
        n_hr_tens  = hr_tens;
        n_hr_ones  = hr_ones;
        n_min_tens = min_tens;
        n_min_ones = min_ones;
        if (edit_req) begin
            if (sel[0]) begin
                n_min_ones = digit_step(min_ones, 4'd9, up);
            end else if (sel[1]) begin
                n_min_tens = digit_step(min_tens, 4'd5, up);
            end else if (sel[2]) begin
                n_hr_ones = digit_step(hr_ones, (hr_tens == 4'd2) ? 4'd3 : 4'd9, up);
            end else begin
                n_hr_tens = digit_step(hr_tens, 4'd2, up);
                // Moving into the 20s must not leave an illegal 24..29 hour.
                if (n_hr_tens == 4'd2 && hr_ones > 4'd3)
                    n_hr_ones = 4'd3;
            end
        end
        edit_bcd = {n_hr_tens, n_hr_ones, n_min_tens, n_min_ones};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            active_q  <= 1'b0;
            working   <= RESET_BCD;
            alarm_bcd <= RESET_BCD;
            disp_bcd  <= RESET_BCD;
            editing   <= 1'b0;
            saved     <= 1'b0;
        end else begin
            active_q <= active;
            saved    <= 1'b0;
            unique case (state)
                IDLE: begin
                    disp_bcd <= alarm_bcd;
                    if (active) begin
                        state   <= EDIT;
                        working <= alarm_bcd;
                        editing <= 1'b1;
                    end
                end
                EDIT: begin
                    if (cancel) begin
                        state    <= ABORT;
                        working  <= alarm_bcd;
                        disp_bcd <= alarm_bcd;
                        editing  <= 1'b0;
                    end else if (active_q && !active) begin
                        state     <= IDLE;
                        alarm_bcd <= working;
                        disp_bcd  <= working;
                        editing   <= 1'b0;
                        saved     <= 1'b1;
                    end else begin
                        working  <= edit_bcd;
                        disp_bcd <= edit_bcd;
                    end
                end
                ABORT: begin
                    disp_bcd <= alarm_bcd;
                    if (!active)
                        state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    disp_bcd <= alarm_bcd;
                    editing  <= 1'b0;
                end
            endcase
        end
    end

`ifdef EDIT_BLINK_EN
    logic [BLINK_DIV-1:0] blink_cnt;
    logic [BLINK_DIV-1:0] blink_cnt_nxt;
    logic                 stay_edit;
    logic                 blink_restart;

    // Counter restarts on entry and on every edit so the edited digit is shown at once.
    always_comb begin
        stay_edit     = (state == IDLE && active) || (state == EDIT && active && !cancel);
        blink_restart = (state == IDLE && active) ||
                        (state == EDIT && active && !cancel && edit_req);
        blink_cnt_nxt = blink_restart ? '0 : blink_cnt + {{(BLINK_DIV-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt  <= '0;
            blank_mask <= 4'b0000;
        end else begin
            blink_cnt  <= blink_cnt_nxt;
            blank_mask <= (stay_edit && sel_one) ?
                          (sel[3:0] & {4{blink_cnt_nxt[BLINK_DIV-1]}}) : 4'b0000;
        end
    end
`else
    logic unused_blink_div;
    assign unused_blink_div = (BLINK_DIV > 0);
    assign blank_mask       = 4'b0000;
`endif

endmodule

// File: tb/tb_alarm_time_editor.sv
// Bench for alarm_time_editor: directed scenarios plus randomized traffic against a digit-level model.
module tb_alarm_time_editor;

    logic        clk = 1'b0;
    logic        reset;
    logic        active;
    logic [7:0]  sel;
    logic        up;
    logic        down;
    logic        cancel;
    logic [15:0] alarm_bcd;
    logic [15:0] disp_bcd;
    logic        editing;
    logic        saved;
    logic [3:0]  blank_mask;

    int checks = 0;
    int errors = 0;

    // Reference model: committed time, working time, and where the user is in the edit flow.
    logic [15:0] m_alarm, m_work, m_disp;
    logic        m_in_edit, m_aborted, m_edit, m_saved;

    alarm_time_editor dut (
        .clk        (clk),
        .reset      (reset),
        .active     (active),
        .sel        (sel),
        .up         (up),
        .down       (down),
        .cancel     (cancel),
        .alarm_bcd  (alarm_bcd),
        .disp_bcd   (disp_bcd),
        .editing    (editing),
        .saved      (saved),
        .blank_mask (blank_mask)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] apply_edit(input logic [15:0] t, input logic [7:0] s,
                                               input logic u, input logic dn);
        int ht, ho, mt, mo, dir, hmod;
        ht = int'(t[15:12]);
        ho = int'(t[11:8]);
        mt = int'(t[7:4]);
        mo = int'(t[3:0]);
        if ($countones(s[3:0]) != 1 || u == dn) return t;
        dir = u ? 1 : -1;
        if (s[0]) mo = (mo + dir + 10) % 10;
        else if (s[1]) mt = (mt + dir + 6) % 6;
        else if (s[2]) begin
            hmod = (ht == 2) ? 4 : 10;
            ho = (ho + dir + hmod) % hmod;
        end else begin
            ht = (ht + dir + 3) % 3;
            if (ht == 2 && ho > 3) ho = 3;
        end
        return {4'(ht), 4'(ho), 4'(mt), 4'(mo)};
    endfunction

    task automatic model_reset();
        m_alarm = 16'h0600; m_work = 16'h0600; m_disp = 16'h0600;
        m_in_edit = 1'b0; m_aborted = 1'b0; m_edit = 1'b0; m_saved = 1'b0;
    endtask

    task automatic model_step(input logic a, input logic [7:0] s, input logic u,
                              input logic dn, input logic c);
        m_saved = 1'b0;
        if (m_aborted) begin
            if (!a) m_aborted = 1'b0;
        end else if (m_in_edit) begin
            if (c) begin
                m_in_edit = 1'b0; m_aborted = 1'b1; m_work = m_alarm;
            end else if (!a) begin
                m_in_edit = 1'b0; m_alarm = m_work; m_saved = 1'b1;
            end else begin
                m_work = apply_edit(m_work, s, u, dn);
            end
        end else if (a) begin
            m_in_edit = 1'b1; m_work = m_alarm;
        end
        m_edit = m_in_edit;
        m_disp = m_in_edit ? m_work : m_alarm;
    endtask

    task automatic tick(input logic a, input logic [7:0] s, input logic u,
                        input logic dn, input logic c);
        active = a; sel = s; up = u; down = dn; cancel = c;
        @(posedge clk);
        model_step(a, s, u, dn, c);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (alarm_bcd !== 16'h0600) begin errors++; $display("FAIL reset_alarm: got %h want 0600", alarm_bcd); end
        checks++; if (disp_bcd !== 16'h0600) begin errors++; $display("FAIL reset_disp: got %h want 0600", disp_bcd); end
        tick(1, 8'h01, 0, 0, 0);
        tick(1, 8'h01, 1, 0, 0);
        checks++; if (disp_bcd !== 16'h0601) begin errors++; $display("FAIL pre_reset_disp: got %h want 0601", disp_bcd); end
        active = 0; sel = 0; up = 0; down = 0; cancel = 0;
        reset = 1'b1;
        #2;
        model_reset();
        checks++; if (alarm_bcd !== 16'h0600) begin errors++; $display("FAIL midreset_alarm: got %h want 0600", alarm_bcd); end
        checks++; if (disp_bcd !== 16'h0600) begin errors++; $display("FAIL midreset_disp: got %h want 0600", disp_bcd); end
        checks++; if (editing !== 1'b0) begin errors++; $display("FAIL midreset_editing: got %b want 0", editing); end
        checks++; if (saved !== 1'b0) begin errors++; $display("FAIL midreset_saved: got %b want 0", saved); end
        checks++; if (blank_mask !== 4'b0000) begin errors++; $display("FAIL midreset_blank: got %b want 0000", blank_mask); end
        @(posedge clk);
        #1 reset = 1'b0;
        tick(0, 0, 0, 0, 0);
        checks++; if (saved !== 1'b0 || alarm_bcd !== 16'h0600) begin
            errors++; $display("FAIL postreset_idle: saved %b alarm %h want 0 0600", saved, alarm_bcd);
        end
    endtask

    task automatic test_commit();
        int nsaved;
        logic [15:0] exp;
        tick(1, 8'h01, 0, 0, 0);
        checks++; if (editing !== 1'b1 || disp_bcd !== 16'h0600) begin
            errors++; $display("FAIL entry: editing %b disp %h want 1 0600", editing, disp_bcd);
        end
        for (int i = 1; i <= 3; i++) begin
            tick(1, 8'h01, 1, 0, 0);
            exp = 16'h0600 + 16'(i);
            checks++; if (disp_bcd !== exp) begin errors++; $display("FAIL commit_up%0d: got %h want %h", i, disp_bcd, exp); end
        end
        nsaved = 0;
        tick(0, 8'h01, 0, 0, 0);
        if (saved === 1'b1) nsaved++;
        checks++; if (alarm_bcd !== 16'h0603 || editing !== 1'b0) begin
            errors++; $display("FAIL commit_alarm: alarm %h editing %b want 0603 0", alarm_bcd, editing);
        end
        tick(1, 8'h00, 0, 0, 0);
        if (saved === 1'b1) nsaved++;
        checks++; if (nsaved != 1) begin errors++; $display("FAIL commit_saved_len: got %0d cycles want 1", nsaved); end
        checks++; if (editing !== 1'b1 || disp_bcd !== 16'h0603) begin
            errors++; $display("FAIL reentry: editing %b disp %h want 1 0603", editing, disp_bcd);
        end
        tick(0, 0, 0, 0, 0);
        checks++; if (saved !== 1'b1 || alarm_bcd !== 16'h0603) begin
            errors++; $display("FAIL recommit: saved %b alarm %h want 1 0603", saved, alarm_bcd);
        end
        tick(0, 0, 0, 0, 0);
    endtask

    task automatic test_wrap();
        tick(1, 8'h00, 0, 0, 0);
        tick(1, 8'h02, 0, 1, 0);
        for (int i = 0; i < 3; i++) tick(1, 8'h01, 0, 1, 0);
        checks++; if (disp_bcd !== 16'h0650) begin errors++; $display("FAIL wrap_setup: got %h want 0650", disp_bcd); end
        tick(1, 8'h02, 1, 0, 0);
        checks++; if (disp_bcd !== 16'h0600) begin errors++; $display("FAIL mt_up_wrap: got %h want 0600", disp_bcd); end
        tick(1, 8'h02, 0, 1, 0);
        checks++; if (disp_bcd !== 16'h0650) begin errors++; $display("FAIL mt_down_wrap: got %h want 0650", disp_bcd); end
        tick(1, 8'h02, 1, 0, 0);
        tick(1, 8'h01, 0, 1, 0);
        checks++; if (disp_bcd !== 16'h0609) begin errors++; $display("FAIL mo_down_wrap: got %h want 0609", disp_bcd); end
        tick(1, 8'h01, 1, 0, 0);
        checks++; if (disp_bcd !== 16'h0600) begin errors++; $display("FAIL mo_up_wrap: got %h want 0600", disp_bcd); end
        tick(0, 0, 0, 0, 0);
        checks++; if (alarm_bcd !== 16'h0600) begin errors++; $display("FAIL wrap_commit: got %h want 0600", alarm_bcd); end
    endtask

    task automatic test_hours();
        tick(1, 8'h00, 0, 0, 0);
        tick(1, 8'h08, 1, 0, 0);
        tick(1, 8'h04, 1, 0, 0);
        checks++; if (disp_bcd !== 16'h1700) begin errors++; $display("FAIL hr_setup: got %h want 1700", disp_bcd); end
        tick(1, 8'h08, 1, 0, 0);
        checks++; if (disp_bcd !== 16'h2300) begin errors++; $display("FAIL hr_clamp: got %h want 2300", disp_bcd); end
        tick(1, 8'h04, 1, 0, 0);
        checks++; if (disp_bcd !== 16'h2000) begin errors++; $display("FAIL ho_wrap_20s: got %h want 2000", disp_bcd); end
        tick(1, 8'h08, 1, 0, 0);
        checks++; if (disp_bcd !== 16'h0000) begin errors++; $display("FAIL ht_up_wrap: got %h want 0000", disp_bcd); end
        tick(1, 8'h08, 0, 1, 0);
        checks++; if (disp_bcd !== 16'h2000) begin errors++; $display("FAIL ht_down_wrap: got %h want 2000", disp_bcd); end
        tick(1, 8'h04, 0, 1, 0);
        checks++; if (disp_bcd !== 16'h2300) begin errors++; $display("FAIL ho_down_20s: got %h want 2300", disp_bcd); end
        tick(1, 8'h00, 0, 0, 1);
        checks++; if (disp_bcd !== 16'h0600) begin errors++; $display("FAIL hr_cancel_disp: got %h want 0600", disp_bcd); end
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
    endtask

    task automatic test_cancel();
        tick(1, 8'h00, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(1, 8'h02, 1, 0, 0);
        for (int i = 0; i < 5; i++) tick(1, 8'h01, 1, 0, 0);
        checks++; if (disp_bcd !== 16'h0645) begin errors++; $display("FAIL cancel_setup: got %h want 0645", disp_bcd); end
        tick(1, 8'h01, 0, 0, 1);
        checks++; if (disp_bcd !== 16'h0600 || editing !== 1'b0 || saved !== 1'b0) begin
            errors++; $display("FAIL cancel: disp %h editing %b saved %b want 0600 0 0", disp_bcd, editing, saved);
        end
        tick(1, 8'h01, 1, 0, 0);
        checks++; if (disp_bcd !== 16'h0600) begin errors++; $display("FAIL abort_ignores_up: got %h want 0600", disp_bcd); end
        tick(0, 0, 0, 0, 0);
        checks++; if (saved !== 1'b0 || alarm_bcd !== 16'h0600) begin
            errors++; $display("FAIL abort_exit: saved %b alarm %h want 0 0600", saved, alarm_bcd);
        end
        tick(0, 0, 0, 0, 0);
        checks++; if (saved !== 1'b0) begin errors++; $display("FAIL abort_no_save: got %b want 0", saved); end
        tick(1, 8'h00, 0, 0, 0);
        tick(1, 8'h01, 1, 0, 0);
        tick(0, 8'h01, 0, 0, 1);
        checks++; if (saved !== 1'b0 || editing !== 1'b0 || alarm_bcd !== 16'h0600) begin
            errors++; $display("FAIL cancel_on_fall: saved %b editing %b alarm %h want 0 0 0600", saved, editing, alarm_bcd);
        end
        tick(0, 0, 0, 0, 0);
        checks++; if (saved !== 1'b0 || alarm_bcd !== 16'h0600 || disp_bcd !== 16'h0600) begin
            errors++; $display("FAIL cancel_on_fall_after: saved %b alarm %h disp %h", saved, alarm_bcd, disp_bcd);
        end
    endtask

    task automatic test_ignored();
        logic [7:0] sv [5] = '{8'h01, 8'h10, 8'h03, 8'h00, 8'hF0};
        logic       uv [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic       dv [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tick(1, 8'h00, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick(1, sv[i], uv[i], dv[i], 0);
            checks++; if (disp_bcd !== 16'h0600) begin
                errors++; $display("FAIL ignored_%0d: sel %h got %h want 0600", i, sv[i], disp_bcd);
            end
        end
        tick(1, 8'h21, 1, 0, 0);
        checks++; if (disp_bcd !== 16'h0601) begin errors++; $display("FAIL sel_hi_ignored: got %h want 0601", disp_bcd); end
        tick(1, 8'h00, 0, 0, 1);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic       a = 1'b0;
        logic [7:0] s;
        logic       u, dn, c;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) == 0) a = ~a;
            case ($urandom_range(0, 5))
                0, 1, 2, 3: s = 8'(1 << $urandom_range(0, 3));
                4:          s = 8'($urandom);
                default:    s = 8'h00;
            endcase
            u  = ($urandom_range(0, 2) == 0);
            dn = ($urandom_range(0, 2) == 0);
            c  = ($urandom_range(0, 39) == 0);
            tick(a, s, u, dn, c);
            checks++; if (alarm_bcd !== m_alarm) begin errors++; $display("FAIL rnd_alarm @%0d: got %h want %h", n, alarm_bcd, m_alarm); end
            checks++; if (disp_bcd !== m_disp) begin errors++; $display("FAIL rnd_disp @%0d: got %h want %h", n, disp_bcd, m_disp); end
            checks++; if (editing !== m_edit) begin errors++; $display("FAIL rnd_editing @%0d: got %b want %b", n, editing, m_edit); end
            checks++; if (saved !== m_saved) begin errors++; $display("FAIL rnd_saved @%0d: got %b want %b", n, saved, m_saved); end
`ifndef EDIT_BLINK_EN
            checks++; if (blank_mask !== 4'b0000) begin errors++; $display("FAIL rnd_blank @%0d: got %b want 0000", n, blank_mask); end
`endif
        end
    endtask

    initial begin
        reset = 1'b1; active = 0; sel = 0; up = 0; down = 0; cancel = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        test_reset();
        test_commit();
        test_wrap();
        test_hours();
        test_cancel();
        test_ignored();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
